// File: rtl/branch_pkg.sv
// Shared types for the branch condition unit: branch kinds, condition codes and the flag word.
package branch_pkg;

   localparam int FLAG_W = 4;

   typedef enum logic [1:0] {
      BK_BCOND = 2'b00,
      BK_CBZ   = 2'b01,
      BK_CBNZ  = 2'b10,
      BK_B     = 2'b11
   } br_kind_e;

   typedef enum logic [3:0] {
      EQ, NE, HS, LO, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
   } cond_e;

   // Bit order matches the flags_q port: {N, Z, V, C}.
   typedef struct packed {
      logic n;
      logic z;
      logic v;
      logic c;
   } flags_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational B.cond decode: odd codes are the inverse of the even code below them, 111x always taken.
module cond_eval
   import branch_pkg::*;
(
   input  logic [3:0] cond,
   input  logic       n,
   input  logic       z,
   input  logic       v,
   input  logic       c,
   output logic       taken
);

   logic [2:0] base_sel;
   logic       base;

   assign base_sel = cond[3:1];

   // NOTE: every signal written in always_comb gets a value on every path, otherwise a latch is inferred.
   always_comb begin
      base = 1'b0;
      unique case (base_sel)
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c & ~z;
         3'd5: base = (n == v);
         3'd6: base = ~z & (n == v);
         3'd7: base = 1'b1;
      endcase
   end

   assign taken = (base_sel == 3'd7) ? 1'b1 : (base ^ cond[0]);

endmodule

// File: rtl/branch_cond_unit.sv
// Branch resolution with NZVC flag register and statistics counters.
// Build option FLAG_FWD_EN: bypass live ALU flags to a same-cycle B.cond instead of stalling it.
module branch_cond_unit
   import branch_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_negative,
   input  logic              alu_zero,
   input  logic              alu_overflow,
   input  logic              alu_carry_out,
   input  logic              flags_we,
   input  logic              br_valid,
   output logic              br_ready,
   input  logic [1:0]        br_kind,
   input  logic [3:0]        br_cond,
   input  logic              flush,
   output logic              res_valid,
   output logic              res_taken,
   output logic [FLAG_W-1:0] flags_q,
   output logic [CNT_W-1:0]  br_cnt,
   output logic [CNT_W-1:0]  taken_cnt
);

   flags_t   live_flags;
   flags_t   flags_r;
   flags_t   eval_flags;
   br_kind_e kind;
   logic     cond_taken;
   logic     taken_next;
   logic     accept;

   assign live_flags = {alu_negative, alu_zero, alu_overflow, alu_carry_out};
   assign kind       = br_kind_e'(br_kind);

`ifdef FLAG_FWD_EN
   assign eval_flags = flags_we ? live_flags : flags_r;
   assign br_ready   = 1'b1;
`else
   // A B.cond racing a flag write waits one cycle and then reads the registered flags.
   assign eval_flags = flags_r;
   assign br_ready   = ~(br_valid && (kind == BK_BCOND) && flags_we);
`endif

   cond_eval u_cond_eval (
      .cond  (br_cond),
      .n     (eval_flags.n),
      .z     (eval_flags.z),
      .v     (eval_flags.v),
      .c     (eval_flags.c),
      .taken (cond_taken)
   );

   always_comb begin
      taken_next = 1'b0;
      unique case (kind)
         BK_BCOND: taken_next = cond_taken;
         BK_CBZ:   taken_next = alu_zero;
         BK_CBNZ:  taken_next = ~alu_zero;
         BK_B:     taken_next = 1'b1;
      endcase
   end

   assign accept = br_valid & br_ready & ~flush;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_r <= '0;
      end else if (flags_we) begin
         flags_r <= live_flags;
      end
   end

   // NOTE: only control state and counters are reset; there is no storage array here to clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_taken <= 1'b0;
         br_cnt    <= '0;
         taken_cnt <= '0;
      end else begin
         res_valid <= accept;
         res_taken <= accept & taken_next;
         if (accept) begin
            br_cnt <= br_cnt + 1'b1;
            if (taken_next) taken_cnt <= taken_cnt + 1'b1;
         end
      end
   end

   assign flags_q = flags_r;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: directed scenarios followed by random traffic vs a cycle model.
module tb_branch_cond_unit;

   localparam int CNT_W = 4;
   localparam int CNT_MOD = 1 << CNT_W;
`ifdef FLAG_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             alu_negative, alu_zero, alu_overflow, alu_carry_out;
   logic             flags_we, br_valid, br_ready, flush;
   logic [1:0]       br_kind;
   logic [3:0]       br_cond;
   logic             res_valid, res_taken;
   logic [3:0]       flags_q;
   logic [CNT_W-1:0] br_cnt, taken_cnt;

   int checks = 0;
   int errors = 0;

   // Reference state
   int m_flags, m_br, m_taken;
   bit m_rv, m_rt;

   branch_cond_unit #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_negative(alu_negative), .alu_zero(alu_zero),
      .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
      .flags_we(flags_we), .br_valid(br_valid), .br_ready(br_ready),
      .br_kind(br_kind), .br_cond(br_cond), .flush(flush),
      .res_valid(res_valid), .res_taken(res_taken), .flags_q(flags_q),
      .br_cnt(br_cnt), .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Condition table written out code by code from the architectural definition.
   function automatic bit ref_cond(int cc, bit n, bit z, bit v, bit c);
      case (cc)
         0:  return z;
         1:  return !z;
         2:  return c;
         3:  return !c;
         4:  return n;
         5:  return !n;
         6:  return v;
         7:  return !v;
         8:  return c && !z;
         9:  return !c || z;
         10: return n == v;
         11: return n != v;
         12: return !z && (n == v);
         13: return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   task automatic model_reset();
      m_flags = 0; m_br = 0; m_taken = 0; m_rv = 0; m_rt = 0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".res_valid"}, res_valid, m_rv);
      check({tag, ".res_taken"}, res_taken, m_rt);
      check({tag, ".flags_q"},   flags_q,   m_flags);
      check({tag, ".br_cnt"},    br_cnt,    m_br);
      check({tag, ".taken_cnt"}, taken_cnt, m_taken);
   endtask

   // One clock cycle: drive, check ready, clock, advance model, check outputs.
   task automatic step(input string tag, input bit valid, input int kind, input int cc,
                       input bit we, input bit n, input bit z, input bit v, input bit c,
                       input bit fl);
      bit exp_ready, acc, tk;
      int ef;
      br_valid = valid; br_kind = kind[1:0]; br_cond = cc[3:0]; flags_we = we;
      alu_negative = n; alu_zero = z; alu_overflow = v; alu_carry_out = c; flush = fl;
      #1;
      exp_ready = !(valid && kind == 0 && we && !FWD);
      check({tag, ".br_ready"}, br_ready, exp_ready);
      acc = valid && exp_ready && !fl;
      ef  = (FWD && we) ? {n, z, v, c} : m_flags;
      case (kind)
         0: tk = ref_cond(cc, ef[3], ef[2], ef[1], ef[0]);
         1: tk = z;
         2: tk = !z;
         default: tk = 1'b1;
      endcase
      @(posedge clk);
      m_rv = acc;
      m_rt = acc && tk;
      if (acc) begin
         m_br = (m_br + 1) % CNT_MOD;
         if (tk) m_taken = (m_taken + 1) % CNT_MOD;
      end
      if (we) m_flags = {n, z, v, c};
      #1;
      check_outputs(tag);
   endtask

   task automatic idle(input string tag);
      step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int br_before;
      rst_n = 1'b0;
      {alu_negative, alu_zero, alu_overflow, alu_carry_out} = 4'b0;
      flags_we = 0; br_valid = 0; br_kind = 0; br_cond = 0; flush = 0;
      model_reset();
      #2;
      check_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle("idle0");

      // SUBS 5-5 sets Z and C, then EQ taken / NE not taken
      step("subs", 0, 0, 0, 1, 0, 1, 0, 1, 0);
      step("eq", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("eq.taken_const", res_taken, 1);
      step("ne", 1, 0, 1, 0, 0, 0, 0, 0, 0);
      check("ne.taken_const", res_taken, 0);

      // Signed compares with N=1 V=0, then N=1 V=1
      step("setnv10", 0, 0, 0, 1, 1, 0, 0, 0, 0);
      step("lt", 1, 0, 11, 0, 0, 0, 0, 0, 0);
      check("lt.taken_const", res_taken, 1);
      step("ge", 1, 0, 10, 0, 0, 0, 0, 0, 0);
      check("ge.taken_const", res_taken, 0);
      step("gt", 1, 0, 12, 0, 0, 0, 0, 0, 0);
      step("le", 1, 0, 13, 0, 0, 0, 0, 0, 0);
      check("le.taken_const", res_taken, 1);
      step("setnv11", 0, 0, 0, 1, 1, 0, 1, 0, 0);
      step("ge2", 1, 0, 10, 0, 0, 0, 0, 0, 0);
      check("ge2.taken_const", res_taken, 1);

      // Same-cycle hazard from flags 0000
      step("clr", 0, 0, 0, 1, 0, 0, 0, 0, 0);
      step("haz", 1, 0, 0, 1, 0, 1, 0, 0, 0);
      if (FWD) check("haz.fwd_taken", res_taken, 1);
      else     check("haz.stall_valid", res_valid, 0);
      step("haz_retry", 1, 0, 0, 0, 0, 1, 0, 0, 0);
      check("haz_retry.taken", res_taken, 1);

      // CBZ / CBNZ with alu_zero=1 leave flags untouched
      step("cbz", 1, 1, 0, 0, 0, 1, 0, 0, 0);
      check("cbz.taken_const", res_taken, 1);
      step("cbnz", 1, 2, 0, 0, 0, 1, 0, 0, 0);
      check("cbnz.taken_const", res_taken, 0);

      // Flush, then 3 B and one failing EQ
      step("zflags", 0, 0, 0, 1, 0, 0, 0, 0, 0);
      br_before = m_br;
      step("flush", 1, 3, 0, 0, 0, 0, 0, 0, 1);
      check("flush.br_cnt_hold", br_cnt, br_before);
      rst_n = 1'b0; #1; rst_n = 1'b1; model_reset();
      check_outputs("clear");
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) step("b", 1, 3, 0, 0, 0, 0, 0, 0, 0);
      step("eqfail", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("cnt.br4", br_cnt, 4);
      check("cnt.taken3", taken_cnt, 3);

      // Reset asserted while a result is pending
      step("setflags", 0, 0, 0, 1, 1, 1, 1, 1, 0);
      step("pend", 1, 3, 0, 0, 0, 0, 0, 0, 0);
      br_valid = 1; br_kind = 3;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("midrst");
      br_valid = 0;
      @(posedge clk); #1;
      check_outputs("midrst_hold");
      rst_n = 1'b1;
      idle("post_rst0");
      idle("post_rst1");

      // Random traffic, counters wrap at CNT_W bits
      for (int i = 0; i < 300; i++) begin
         step("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 15),
              $urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/branch_cond_unit.md
BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the branch and taken statistics counters.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-004 SHALL have ports alu_negative, alu_zero, alu_overflow, alu_carry_out, each input, 1: the current-cycle ALU flags.
REQ-005 SHALL have port flags_we, input, 1, high when the EX-stage instruction sets flags (ADDS/SUBS).
REQ-006 SHALL have port br_valid, input, 1, branch request present.
REQ-007 SHALL have port br_ready, output, 1, request accepted this cycle.
REQ-008 SHALL have port br_kind, input, 2: 00 B.cond, 01 CBZ, 10 CBNZ, 11 B.
REQ-009 SHALL have port br_cond, input, 4, condition code; used only for B.cond.
REQ-010 SHALL have port flush, input, 1, pipeline squash.
REQ-011 SHALL have ports res_valid and res_taken, outputs, 1 each: the resolved branch result.
REQ-012 SHALL have ports flags_q, output, 4 {N,Z,V,C}, plus br_cnt and taken_cnt, outputs, CNT_W each.

Function
REQ-013 SHALL load flags_q with {alu_negative, alu_zero, alu_overflow, alu_carry_out} at the clock edge when flags_we=1; otherwise flags_q holds.
REQ-014 SHALL accept a request when br_valid && br_ready and drive res_valid=1 exactly one cycle later with the registered res_taken; otherwise res_valid=0.
REQ-015 SHALL evaluate B.cond as follows:
- 0000 EQ Z; 0001 NE !Z
- 0010 HS C; 0011 LO !C
- 0100 MI N; 0101 PL !N
- 0110 VS V; 0111 VC !V
- 1000 HI C&!Z; 1001 LS !(C&!Z)
- 1010 GE N==V; 1011 LT N!=V
- 1100 GT !Z&(N==V); 1101 LE !(!Z&(N==V))
- 1110 and 1111 always taken
REQ-016 SHALL resolve CBZ as taken when alu_zero=1 in the accept cycle and CBNZ when alu_zero=0; neither kind modifies flags_q.
REQ-017 SHALL always take kind B.
REQ-018 SHALL keep br_ready=1 in every case not listed in REQ-024.
REQ-019 SHALL, when flush=1, force res_valid=0 on the next edge, suppress any acceptance that cycle and leave the counters unchanged; flags_we still updates flags_q.
REQ-020 SHALL increment br_cnt on every accepted, non-flushed request, and increment taken_cnt when that request resolves taken.
REQ-021 SHALL let both counters wrap modulo 2^CNT_W without saturation.
REQ-022 SHALL deassert res_taken whenever res_valid=0.

Reset
REQ-023 SHALL, on rst_n=0 and regardless of clk, immediately drive flags_q=4'b0000, res_valid=0, res_taken=0, br_cnt=0 and taken_cnt=0; any in-flight result is discarded, and operation resumes on the first edge after release.

Configuration
REQ-024 SHALL honour macro FLAG_FWD_EN as follows:
- Defined: a B.cond with flags_we=1 in the same cycle evaluates against the live ALU flags (bypass), and br_ready stays 1.
- Undefined: in that same case br_ready=0 for one cycle; the request is accepted next cycle against the updated flags_q.
- CBZ, CBNZ and B never stall.

Structure
REQ-025 SHALL take enums br_kind_e and cond_e (EQ..NV) and constant FLAG_W=4 from package branch_pkg.
REQ-026 SHALL place the combinational condition decode in sub-module cond_eval (inputs cond, N, Z, V, C; output taken), instantiated once.

Verification
REQ-027 SHALL cover flags-update-then-compare: SUBS 5-5 (Z=1, C=1) with flags_we=1, next cycle B.cond EQ -> one cycle later res_valid=1, res_taken=1, and B.cond NE -> res_taken=0.
REQ-028 SHALL cover signed compare: flags N=1, V=0 -> LT taken, GE not taken, GT not taken, LE taken; N=1, V=1 -> GE taken.
REQ-029 SHALL cover the same-cycle hazard: flags_q=0000, flags_we=1 with ALU Z=1, and B.cond EQ together:
- with FLAG_FWD_EN -> br_ready=1, res_taken=1 next cycle;
- without FLAG_FWD_EN -> br_ready=0 that cycle, accepted next cycle, res_taken=1 one cycle later.
REQ-030 SHALL cover CBZ/CBNZ: CBZ with alu_zero=1 -> taken; CBNZ with alu_zero=1 -> not taken; flags_q unchanged in both cases.
REQ-031 SHALL cover flush and counters: flush=1 coincident with an accepted B -> res_valid=0 next cycle and br_cnt unchanged; 3 B plus 1 failing EQ -> br_cnt=4, taken_cnt=3.
REQ-032 SHALL cover mid-operation reset: rst_n low between accept and result -> res_valid=0, flags_q=0000 and counters=0 immediately, with no result emitted after release.
